// File: rtl/sa_stream_sequencer.sv
// Sequencer that feeds a systolic array (weights, then activation rows, then drain)
// and buffers its results in an output FIFO. Define SA_STREAM_SEQUENCER_PERF_EN for perf counters.
module sa_stream_sequencer #(
  parameter int SA_SIZE        = 4,
  parameter int OUT_FIFO_DEPTH = 8,
  parameter int DRAIN_LEN      = 2 * SA_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [15:0]                num_rows_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_data_i,
  output logic [31:0]                sa_val_o,
  output logic [$clog2(SA_SIZE)-1:0] sa_idx_o,
  output logic [1:0]                 sa_cmd_o,
  input  logic [31:0]                sa_out_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_data_o,
  output logic [31:0]                perf_busy_cycles_o,
  output logic [31:0]                perf_stall_cycles_o
);

  localparam int IDX_W = $clog2(SA_SIZE);
  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_WEIGHTS = 2'd1;
  localparam logic [1:0] CMD_QUEUE   = 2'd2;
  localparam logic [1:0] CMD_STREAM  = 2'd3;

  localparam logic [31:0]  WEIGHT_LAST = 32'(SA_SIZE * SA_SIZE - 1);
  localparam logic [31:0]  DRAIN_LAST  = 32'(DRAIN_LEN - 1);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(OUT_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WEIGHTS, S_STREAM, S_DRAIN, S_FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] total_q, total_d;

  logic [31:0]      mem_q [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = out_valid_o && out_ready_i;

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    sa_cmd_o   = CMD_NONE;
    push       = 1'b0;
    in_ready_o = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WEIGHTS;
          cnt_d   = '0;
          total_d = 32'(num_rows_i) * 32'(SA_SIZE);
        end
      end
      S_WEIGHTS: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          sa_cmd_o = CMD_WEIGHTS;
          if (cnt_q == WEIGHT_LAST) begin
            cnt_d   = '0;
            state_d = (total_q == '0) ? S_DRAIN : S_STREAM;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_STREAM: begin
        in_ready_o = !fifo_full;
        if (in_valid_i && !fifo_full) begin
          sa_cmd_o = CMD_STREAM;
          push     = 1'b1;
          if (cnt_q == total_q - 32'd1) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!fifo_full) begin
          sa_cmd_o = CMD_QUEUE;
          push     = 1'b1;
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign sa_idx_o    = cnt_q[IDX_W-1:0];
  assign sa_val_o    = (sa_cmd_o == CMD_WEIGHTS || sa_cmd_o == CMD_STREAM) ? in_data_i : '0;
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      total_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers/count define validity and out_data_o is gated.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= sa_out_i;
  end

`ifdef SA_STREAM_SEQUENCER_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;
  logic        stall, perf_clr;

  assign stall    = (state_q == S_WEIGHTS || state_q == S_STREAM || state_q == S_DRAIN)
                    && (sa_cmd_o == CMD_NONE);
  assign perf_clr = (state_q == S_IDLE) && start_i;

  // Counters saturate rather than wrap so long jobs never report small numbers.
  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && perf_busy_q != '1) perf_busy_q  <= perf_busy_q + 32'd1;
      if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_stall_cycles_o = perf_stall_q;
`else
  assign perf_busy_cycles_o  = '0;
  assign perf_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_sa_stream_sequencer.sv
// Self-checking bench for sa_stream_sequencer: a job-level reference model (phase, word
// counts, expected result queue) is advanced every cycle and compared against the DUT.
module tb_sa_stream_sequencer;

  localparam int SA    = 4;
  localparam int DEPTH = 8;
  localparam int DLEN  = 2 * SA;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] num_rows_i = '0;
  logic        busy_o, done_o;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic [31:0] sa_val_o;
  logic [1:0]  sa_idx_o;
  logic [1:0]  sa_cmd_o;
  logic [31:0] sa_out_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [31:0] perf_busy_cycles_o, perf_stall_cycles_o;

  always #5 clk = ~clk;

  sa_stream_sequencer #(.SA_SIZE(SA), .OUT_FIFO_DEPTH(DEPTH), .DRAIN_LEN(DLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_rows_i(num_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .sa_val_o(sa_val_o), .sa_idx_o(sa_idx_o), .sa_cmd_o(sa_cmd_o), .sa_out_i(sa_out_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .perf_busy_cycles_o(perf_busy_cycles_o), .perf_stall_cycles_o(perf_stall_cycles_o)
  );

  typedef enum int {P_IDLE, P_WEIGHTS, P_STREAM, P_DRAIN, P_FLUSH} phase_e;

  phase_e      m_phase = P_IDLE;
  int unsigned m_cnt = 0;
  int unsigned m_rows = 0;
  logic [31:0] m_busy = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_q [$];

  int checks = 0;
  int errors = 0;
  int n_w, n_s, n_q, n_out, n_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare DUT against the model, then advance the model.
  task automatic cycle(input bit rst, input bit start, input bit valid, input bit oready,
                       input logic [15:0] rows);
    bit          space, issue, stallable, e_valid, e_done;
    logic [1:0]  e_cmd;
    logic [31:0] e_val, e_data, e_pbusy, e_pstall;
    @(negedge clk);
    rst_i = rst; start_i = start; in_valid_i = valid; out_ready_i = oready;
    in_data_i = $urandom; sa_out_i = $urandom; num_rows_i = rows;
    #1;
    space     = (m_q.size() < DEPTH);
    stallable = (m_phase == P_WEIGHTS || m_phase == P_STREAM || m_phase == P_DRAIN);
    issue     = (m_phase == P_WEIGHTS && valid) || (m_phase == P_STREAM && valid && space)
                || (m_phase == P_DRAIN && space);
    e_cmd     = !issue ? 2'd0 : (m_phase == P_WEIGHTS) ? 2'd1 : (m_phase == P_STREAM) ? 2'd3 : 2'd2;
    e_val     = (issue && m_phase != P_DRAIN) ? in_data_i : 32'd0;
    e_valid   = (m_q.size() > 0);
    e_data    = e_valid ? m_q[0] : 32'd0;
    e_done    = (m_phase == P_FLUSH) && (m_q.size() == 0);
`ifdef SA_STREAM_SEQUENCER_PERF_EN
    e_pbusy = m_busy; e_pstall = m_stall;
`else
    e_pbusy = 32'd0;  e_pstall = 32'd0;
`endif
    check("sa_cmd",    32'(sa_cmd_o), 32'(e_cmd));
    check("sa_val",    sa_val_o, e_val);
    if (issue || m_phase == P_IDLE) check("sa_idx", 32'(sa_idx_o), m_cnt % SA);
    check("busy",      32'(busy_o), 32'(m_phase != P_IDLE));
    check("in_ready",  32'(in_ready_o), 32'(m_phase == P_WEIGHTS || (m_phase == P_STREAM && space)));
    check("done",      32'(done_o), 32'(e_done));
    check("out_valid", 32'(out_valid_o), 32'(e_valid));
    check("out_data",  out_data_o, e_data);
    check("perf_busy", perf_busy_cycles_o, e_pbusy);
    check("perf_stall", perf_stall_cycles_o, e_pstall);
    case (sa_cmd_o)
      2'd1: n_w++;
      2'd2: n_q++;
      2'd3: n_s++;
      default: ;
    endcase
    if (out_valid_o && oready) n_out++;
    if (done_o) n_done++;
    if (rst) begin
      m_phase = P_IDLE; m_q.delete(); m_cnt = 0; m_busy = '0; m_stall = '0;
    end else begin
      if (e_valid && oready) void'(m_q.pop_front());
      if (issue && (m_phase == P_STREAM || m_phase == P_DRAIN)) m_q.push_back(sa_out_i);
      if (m_phase != P_IDLE && m_busy != '1) m_busy++;
      if (stallable && !issue && m_stall != '1) m_stall++;
      if (issue) m_cnt++;
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_WEIGHTS; m_cnt = 0; m_rows = rows; m_busy = '0; m_stall = '0;
        end
        P_WEIGHTS: if (m_cnt == SA * SA) begin
          m_cnt = 0; m_phase = (m_rows == 0) ? P_DRAIN : P_STREAM;
        end
        P_STREAM: if (m_cnt == m_rows * SA) begin
          m_cnt = 0; m_phase = P_DRAIN;
        end
        P_DRAIN: if (m_cnt == DLEN) begin
          m_cnt = 0; m_phase = P_FLUSH;
        end
        P_FLUSH: if (e_done) m_phase = P_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic clear_counts();
    n_w = 0; n_s = 0; n_q = 0; n_out = 0; n_done = 0;
  endtask

  // Run cycles until the model returns to IDLE, with a bounded budget.
  task automatic finish_job(input int valid_pct, input int ready_pct, input bit extra_start);
    int budget;
    budget = 3000;
    while (m_phase != P_IDLE && budget > 0) begin
      cycle(1'b0, extra_start && ($urandom_range(9) == 0), $urandom_range(99) < valid_pct,
            $urandom_range(99) < ready_pct, 16'($urandom));
      budget--;
    end
    if (budget == 0) check("job_timeout_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic run_job(input logic [15:0] rows, input int valid_pct, input int ready_pct,
                         input bit extra_start);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, rows);
    finish_job(valid_pct, ready_pct, extra_start);
  endtask

  initial begin
    clear_counts();
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    check("reset_perf_busy", perf_busy_cycles_o, 32'd0);

    // Nominal job, two rows, everything always ready
    clear_counts();
    run_job(16'd2, 100, 100, 1'b0);
    check("job2_weights", n_w, 16); check("job2_stream", n_s, 8);
    check("job2_queue", n_q, 8);    check("job2_results", n_out, 16);
    check("job2_done", n_done, 1);

    // Zero rows: weights then drain only
    clear_counts();
    run_job(16'd0, 100, 100, 1'b0);
    check("job0_weights", n_w, 16); check("job0_stream", n_s, 0);
    check("job0_queue", n_q, 8);    check("job0_results", n_out, 8);
    check("job0_done", n_done, 1);

    // Output back-pressure during STREAM fills the FIFO
    clear_counts();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'd4);
    for (int i = 0; i < 40 && m_phase != P_STREAM; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
    check("bp_out_valid", 32'(out_valid_o), 32'd1);
    finish_job(100, 100, 1'b0);
    check("bp_stream", n_s, 16); check("bp_results", n_out, 24);

    // Start pulses while busy are ignored
    clear_counts();
    run_job(16'd2, 100, 100, 1'b1);
    check("busy_start_weights", n_w, 16); check("busy_start_stream", n_s, 8);
    check("busy_start_queue", n_q, 8);    check("busy_start_done", n_done, 1);

    // Reset in the middle of STREAM, then a clean job
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 40 && m_phase != P_STREAM; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    clear_counts();
    run_job(16'd1, 100, 100, 1'b0);
    check("postrst_stream", n_s, 4); check("postrst_results", n_out, 12);

    // Three idle input cycles during WEIGHTS
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    finish_job(100, 100, 1'b0);
`ifdef SA_STREAM_SEQUENCER_PERF_EN
    check("idle_in_stall", perf_stall_cycles_o, 32'd3);
`else
    check("idle_in_stall", perf_stall_cycles_o, 32'd0);
    check("idle_in_busy", perf_busy_cycles_o, 32'd0);
`endif

    // Randomized jobs with random handshakes and stray starts
    for (int j = 0; j < 8; j++) begin
      clear_counts();
      run_job(16'($urandom_range(0, 4)), 70, 60, 1'b1);
      check("rand_done", n_done, 1);
      for (int k = 0; k < $urandom_range(0, 3); k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
